vx_fifo_arbiter: RTL and testbench



---
 rtl/vx_fifo_arb_pkg.sv | 34 +++
 rtl/VX_fifo_queue.sv | 65 ++++++
 rtl/vx_rr_arbiter.sv | 40 ++++
 rtl/vx_fifo_arbiter.sv | 130 +++++++++++++
 tb/tb_vx_fifo_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/vx_fifo_arb_pkg.sv
`default_nettype none
// =============================================================================
// Module   : vx_fifo_arb_pkg
// Purpose  : Shared width helpers and {tag, data} entry layout for vx_fifo_arbiter
// Revision : 1.0
// =============================================================================
package vx_fifo_arb_pkg;

    localparam int DEFAULT_NUM_REQS = 4;
    localparam int DEFAULT_DATAW    = 32;

    // Index width, kept at least one bit so a single-requester build still elaborates.
    function automatic int calc_tagw(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

    function automatic int entry_width(input int tagw, input int dataw);
        return tagw + dataw;
    endfunction

    // Queue entry layout: tag in the upper bits, payload in the lower DATAW bits.
    function automatic int entry_tag_lsb(input int dataw);
        return dataw;
    endfunction

    function automatic int entry_data_lsb();
        return 0;
    endfunction

    localparam int DEFAULT_TAGW   = calc_tagw(DEFAULT_NUM_REQS);
    localparam int DEFAULT_ENTRYW = entry_width(DEFAULT_TAGW, DEFAULT_DATAW);

endpackage
`default_nettype wire

// File: rtl/VX_fifo_queue.sv
`default_nettype none
// =============================================================================
// Module   : VX_fifo_queue
// Purpose  : Synchronous first-word fall-through FIFO with occupancy output
// Revision : 1.0
// =============================================================================
module VX_fifo_queue #(
    parameter int DATAW     = 32,
    parameter int DEPTH     = 8,
    parameter int ALM_FULL  = DEPTH - 1,
    parameter int ALM_EMPTY = 1,
    parameter int SIZEW     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             empty,
    output logic             alm_empty,
    output logic             full,
    output logic             alm_full,
    output logic [SIZEW-1:0] size
);

    localparam int ADDRW = $clog2(DEPTH);

    logic [DATAW-1:0] r_mem [DEPTH];
    logic [ADDRW-1:0] r_rd_ptr;
    logic [ADDRW-1:0] r_wr_ptr;
    logic [SIZEW-1:0] r_size;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_size   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDRW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDRW'(1);
            if (w_push && !w_pop)      r_size <= r_size + SIZEW'(1);
            else if (w_pop && !w_push) r_size <= r_size - SIZEW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data_in;
    end

    assign data_out  = r_mem[r_rd_ptr];
    assign empty     = (r_size == '0);
    assign full      = (r_size == SIZEW'(DEPTH));
    assign alm_empty = (r_size <= SIZEW'(ALM_EMPTY));
    assign alm_full  = (r_size >= SIZEW'(ALM_FULL));
    assign size      = r_size;

endmodule
`default_nettype wire

// File: rtl/vx_rr_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : vx_rr_arbiter
// Purpose  : Round-robin pick of the first eligible requester at/after a pointer
// Revision : 1.0
// =============================================================================
module vx_rr_arbiter
    import vx_fifo_arb_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int TAGW     = calc_tagw(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] eligible,
    input  logic [TAGW-1:0]     ptr,
    output logic [NUM_REQS-1:0] grant,
    output logic [TAGW-1:0]     grant_idx,
    output logic                grant_valid
);

    int w_idx;

    // Scan from the farthest offset down so the nearest eligible one wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_idx     = 0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            w_idx = (int'(ptr) + k) % NUM_REQS;
            if (eligible[w_idx]) begin
                grant        = '0;
                grant[w_idx] = 1'b1;
                grant_idx    = TAGW'(w_idx);
            end
        end
    end

    assign grant_valid = |eligible;

endmodule
`default_nettype wire

// File: rtl/vx_fifo_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : vx_fifo_arbiter
// Purpose  : Round-robin sharing of one FIFO among requesters, per-requester cap
// Revision : 1.0
// =============================================================================
module vx_fifo_arbiter
    import vx_fifo_arb_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 32,
    parameter int DEPTH    = 8,
    parameter int MAX_OUT  = 4,
    parameter int TAGW     = calc_tagw(NUM_REQS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      rsp_valid,
    output logic [DATAW-1:0]          rsp_data,
    output logic [TAGW-1:0]           rsp_tag,
    input  logic                      rsp_ready,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int ENTRYW = entry_width(TAGW, DATAW);
    localparam int OCCW   = $clog2(DEPTH) + 1;
    localparam int CNTW   = $clog2(MAX_OUT + 1);

    logic [TAGW-1:0]     r_ptr;
    logic [CNTW-1:0]     r_cnt [NUM_REQS];
    logic [NUM_REQS-1:0] w_eligible;
    logic [NUM_REQS-1:0] w_grant;
    logic [TAGW-1:0]     w_grant_idx;
    logic                w_grant_valid;
    logic [ENTRYW-1:0]   w_push_entry;
    logic [ENTRYW-1:0]   w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_alm_empty;
    logic                w_alm_full;
    logic                w_pop;

    // Full blocks every requester even when a pop frees a slot this cycle.
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_elig
        assign w_eligible[i] = req_valid[i] && (r_cnt[i] < CNTW'(MAX_OUT)) && !w_full && !reset;
    end

    vx_rr_arbiter #(
        .NUM_REQS (NUM_REQS),
        .TAGW     (TAGW)
    ) u_arb (
        .eligible    (w_eligible),
        .ptr         (r_ptr),
        .grant       (w_grant),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    assign req_ready    = w_grant;
    assign w_push_entry = {w_grant_idx, req_data[int'(w_grant_idx) * DATAW +: DATAW]};

    VX_fifo_queue #(
        .DATAW (ENTRYW),
        .DEPTH (DEPTH),
        .SIZEW (OCCW)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (w_grant_valid),
        .pop       (w_pop),
        .data_in   (w_push_entry),
        .data_out  (w_head),
        .empty     (w_empty),
        .alm_empty (w_alm_empty),
        .full      (w_full),
        .alm_full  (w_alm_full),
        .size      (occupancy)
    );

    logic w_unused_alm;
    assign w_unused_alm = &{1'b0, w_alm_empty, w_alm_full};

    assign rsp_valid = !w_empty;
    assign rsp_data  = w_head[entry_data_lsb() +: DATAW];
    assign rsp_tag   = w_head[entry_tag_lsb(DATAW) +: TAGW];
    assign w_pop     = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_grant_valid) begin
            r_ptr <= (w_grant_idx == TAGW'(NUM_REQS - 1)) ? '0 : w_grant_idx + TAGW'(1);
        end
    end

    // Grant and pop on the same requester cancel out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (reset) begin
                r_cnt[i] <= '0;
            end else if (w_grant[i] && !(w_pop && rsp_tag == TAGW'(i))) begin
                r_cnt[i] <= r_cnt[i] + CNTW'(1);
            end else if (!w_grant[i] && w_pop && rsp_tag == TAGW'(i)) begin
                r_cnt[i] <= r_cnt[i] - CNTW'(1);
            end
        end
    end

`ifndef SYNTHESIS
    logic [OCCW-1:0] w_cnt_sum;

    always_comb begin
        w_cnt_sum = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_cnt_sum = w_cnt_sum + OCCW'(r_cnt[i]);
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        w_pop |-> (r_cnt[rsp_tag] != '0));

    a_occ_matches_counts: assert property (@(posedge clk) disable iff (reset)
        occupancy == w_cnt_sum);
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_fifo_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_vx_fifo_arbiter
// Purpose  : Directed vector table plus randomized run against a queue model
// Revision : 1.0
// =============================================================================
module tb_vx_fifo_arbiter;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int MAXO  = 2;
    localparam int TW    = 2;
    localparam int OW    = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [TW-1:0]   rsp_tag;
    logic            rsp_ready;
    logic [OW-1:0]   occupancy;

    vx_fifo_arbiter #(
        .NUM_REQS (N),
        .DATAW    (DW),
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAXO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_ready (rsp_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic        rr;
        logic [7:0]  dbase;
        logic [3:0]  ready;
        logic        chk;
        logic        rvalid;
        logic [1:0]  tag;
        logic [31:0] data;
        logic [3:0]  occ;
    } row_t;

    row_t rows[$];

    function automatic void add(input logic rst, input logic [3:0] rv, input logic rr,
                                input logic [7:0] dbase, input logic [3:0] ready,
                                input logic chk, input logic rvalid, input logic [1:0] tag,
                                input logic [31:0] data, input logic [3:0] occ);
        row_t r;
        r.rst = rst; r.rv = rv; r.rr = rr; r.dbase = dbase; r.ready = ready;
        r.chk = chk; r.rvalid = rvalid; r.tag = tag; r.data = data; r.occ = occ;
        rows.push_back(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_table(input logic rst, input logic [3:0] rv, input logic rr,
                               input logic [7:0] dbase);
        reset     = rst;
        req_valid = rv;
        rsp_ready = rr;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {24'h0, dbase} + 32'(i);
    endtask

    // Reference model state: queue contents, per-requester counts, RR pointer.
    int          q_tag[$];
    logic [31:0] q_dat[$];
    int          m_cnt[N];
    int          m_ptr;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;

        // First request after reset
        add(1, 4'h0, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0);
        add(0, 4'b0001, 0, 8'hA5, 4'b0001, 1, 0, 0, 0, 0);
        add(0, 4'b0000, 1, 8'h00, 4'b0000, 1, 1, 0, 32'hA5, 1);
        add(0, 4'b0000, 0, 8'h00, 4'b0000, 1, 0, 0, 0, 0);
        // Fairness until full, then ordered drain
        add(1, 4'h0, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(0, 4'hF, 0, 8'h10, 4'(1 << (k % 4)), 1, k > 0, 0, 32'h10, 4'(k));
        add(0, 4'hF, 0, 8'h10, 4'h0, 1, 1, 0, 32'h10, 8);
        for (int k = 0; k < 8; k++)
            add(0, 4'h0, 1, 8'h00, 4'h0, 1, 1, 2'(k % 4), 32'h10 + 32'(k % 4), 4'(8 - k));
        add(0, 4'h0, 0, 8'h00, 4'h0, 1, 0, 0, 0, 0);
        // Per-requester cap, released by one pop
        add(1, 4'h0, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0);
        add(0, 4'b0100, 0, 8'h30, 4'b0100, 1, 0, 0, 0, 0);
        add(0, 4'b0100, 0, 8'h30, 4'b0100, 1, 1, 2, 32'h32, 1);
        add(0, 4'b0100, 0, 8'h30, 4'b0000, 1, 1, 2, 32'h32, 2);
        add(0, 4'b0100, 1, 8'h30, 4'b0000, 1, 1, 2, 32'h32, 2);
        add(0, 4'b0100, 0, 8'h30, 4'b0100, 1, 1, 2, 32'h32, 1);
        add(0, 4'b0000, 0, 8'h00, 4'b0000, 1, 1, 2, 32'h32, 2);
        // Pointer skip: ptr=1 with only 0 and 3 valid
        add(1, 4'h0, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0);
        add(0, 4'b0001, 0, 8'h50, 4'b0001, 1, 0, 0, 0, 0);
        add(0, 4'b1001, 0, 8'h50, 4'b1000, 1, 1, 0, 32'h50, 1);
        add(0, 4'b1001, 0, 8'h50, 4'b0001, 1, 1, 0, 32'h50, 2);
        add(0, 4'b0110, 0, 8'h50, 4'b0010, 1, 1, 0, 32'h50, 3);
        // Streaming: push and pop every cycle
        add(1, 4'h0, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0);
        add(0, 4'b0001, 1, 8'h40, 4'b0001, 1, 0, 0, 0, 0);
        for (int k = 1; k < 6; k++)
            add(0, 4'b0001, 1, 8'h40 + 8'(k), 4'b0001, 1, 1, 0, 32'h40 + 32'(k - 1), 1);
        // Reset with five entries queued
        add(1, 4'h0, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            add(0, 4'b0111, 0, 8'h60, 4'(1 << (k % 3)), 1, k > 0, 0, 32'h60, 4'(k));
        add(0, 4'h0, 0, 8'h00, 4'h0, 1, 1, 0, 32'h60, 5);
        add(1, 4'hF, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0);
        add(0, 4'hF, 0, 8'h70, 4'b0001, 1, 0, 0, 0, 0);
        add(0, 4'h0, 0, 8'h00, 4'h0, 1, 1, 0, 32'h70, 1);

        @(posedge clk); #1;
        foreach (rows[j]) begin
            drive_table(rows[j].rst, rows[j].rv, rows[j].rr, rows[j].dbase);
            #1;
            check($sformatf("row%0d_ready", j), 32'(req_ready), 32'(rows[j].ready));
            if (rows[j].chk) begin
                check($sformatf("row%0d_rsp_valid", j), 32'(rsp_valid), 32'(rows[j].rvalid));
                check($sformatf("row%0d_occ", j), 32'(occupancy), 32'(rows[j].occ));
                if (rows[j].rvalid) begin
                    check($sformatf("row%0d_tag", j), 32'(rsp_tag), 32'(rows[j].tag));
                    check($sformatf("row%0d_data", j), rsp_data, rows[j].data);
                end
            end
            @(posedge clk); #1;
        end

        // Randomized traffic against the queue model
        for (int cyc = 0; cyc < 600; cyc++) begin
            int g;
            logic rst_now;
            logic [N-1:0] rv;
            logic rr;
            rst_now = (cyc < 2) || ($urandom_range(0, 99) == 0);
            rv      = N'($urandom);
            rr      = ($urandom_range(0, 3) != 0);
            reset     = rst_now;
            req_valid = rv;
            rsp_ready = rr;
            for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
            #1;
            g = -1;
            if (!rst_now && q_tag.size() < DEPTH) begin
                for (int k = N - 1; k >= 0; k--) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (rv[idx] && m_cnt[idx] < MAXO) g = idx;
                end
            end
            check("rnd_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'h0);
            if (!rst_now) begin
                check("rnd_rsp_valid", 32'(rsp_valid), 32'(q_tag.size() != 0));
                check("rnd_occ", 32'(occupancy), 32'(q_tag.size()));
                if (q_tag.size() != 0) begin
                    check("rnd_tag", 32'(rsp_tag), 32'(q_tag[0]));
                    check("rnd_data", rsp_data, q_dat[0]);
                end
            end
            if (rst_now) begin
                q_tag.delete();
                q_dat.delete();
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
                m_ptr = 0;
            end else begin
                if (q_tag.size() != 0 && rr) begin
                    m_cnt[q_tag[0]]--;
                    void'(q_tag.pop_front());
                    void'(q_dat.pop_front());
                end
                if (g >= 0) begin
                    q_tag.push_back(g);
                    q_dat.push_back(req_data[g*DW +: DW]);
                    m_cnt[g]++;
                    m_ptr = (g + 1) % N;
                end
            end
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
